// File: rtl/multiplier_controller_taint_track_1bit_pkg.sv
// Shared definitions for the taint-tracking shift-add multiplier: state encoding
// and default operand width, imported by controller, datapath and wrapper.
package multiplier_controller_taint_track_1bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/multiplier_controller_taint_track_1bit.sv
// Control FSM for the sequential shift-add multiplier with a sticky 1-bit
// control taint that follows caller-supplied and data-dependent taint.
module multiplier_controller_taint_track_1bit
  import multiplier_controller_taint_track_1bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             done,
  output logic             done_t,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ctrl_t;
  logic          w_ctrl_t_nxt;

  // State, bit counter and sticky control taint registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ctrl_t <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ctrl_t <= w_ctrl_t_nxt;
    end
  end

  // Taint is only picked up while waiting for a request and never cleared.
  always_comb begin
    if (r_state == ST_IDLE && start_t) begin
      w_ctrl_t_nxt = 1'b1;
    end else begin
      w_ctrl_t_nxt = r_ctrl_t;
    end
  end

  // Next-state and strobe decode from the state register.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mrld        = 1'b0;
    mdld        = 1'b0;
    rsclear     = 1'b0;
    rsload      = 1'b0;
    rsshr       = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_INIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INIT: begin
        mrld        = 1'b1;
        mdld        = 1'b1;
        rsclear     = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_ADD;
      end
      ST_ADD: begin
        rsload      = multiplierReg[r_cnt];
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        rsshr = 1'b1;
        // Counter holds at the last bit so it never wraps inside an operation.
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = ST_ADD;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign mrld_t    = r_ctrl_t;
  assign mdld_t    = r_ctrl_t;
  assign rsclear_t = r_ctrl_t;
  assign rsshr_t   = r_ctrl_t;
  assign done_t    = r_ctrl_t;
  // Only the add decision looks at multiplier data, so only it inherits that taint.
  assign rsload_t  = r_ctrl_t | ((r_state == ST_ADD) & multiplierReg_t);

endmodule

// File: tb/tb_multiplier_controller_taint_track_1bit.sv
// Directed bench for the multiplier controller, closed around a behavioural
// shift-add datapath so that products can be checked as well as strobes.
module tb_multiplier_controller_taint_track_1bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start_t = 1'b0;
  logic         mr_t_in = 1'b0;
  logic [W-1:0] mr_in = '0;
  logic [W-1:0] md_in = '0;
  logic         mrld, mrld_t, mdld, mdld_t, rsclear, rsclear_t;
  logic         rsload, rsload_t, rsshr, rsshr_t, done, done_t, busy;

  logic [W-1:0] mr_m;
  logic [W-1:0] md_m;
  logic [9:0]   rs_m;

  int checks = 0;
  int errors = 0;
  logic hold = 1'b0;

  logic [31:0] obs_mrld, obs_rsload, obs_rsshr, obs_done, obs_busy;
  logic [31:0] obs_tall, obs_tany, obs_rsload_t;
  logic [7:0]  cap_prod [0:31];

  multiplier_controller_taint_track_1bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t),
    .multiplierReg(mr_m), .multiplierReg_t(mr_t_in),
    .mrld(mrld), .mrld_t(mrld_t), .mdld(mdld), .mdld_t(mdld_t),
    .rsclear(rsclear), .rsclear_t(rsclear_t), .rsload(rsload), .rsload_t(rsload_t),
    .rsshr(rsshr), .rsshr_t(rsshr_t), .done(done), .done_t(done_t), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: add multiplicand into upper half, then shift right.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mr_m <= '0;
      md_m <= '0;
      rs_m <= '0;
    end else begin
      if (mrld) mr_m <= mr_in;
      if (mdld) md_m <= md_in;
      if (rsclear) rs_m <= '0;
      else if (rsload) rs_m <= rs_m + (10'(md_m) << W);
      else if (rsshr) rs_m <= rs_m >> 1;
    end
  end

  function automatic logic [12:0] all_outs();
    return {mrld, mrld_t, mdld, mdld_t, rsclear, rsclear_t, rsload, rsload_t,
            rsshr, rsshr_t, done, done_t, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records one bit per cycle, starting at the cycle where start is presented.
  task automatic capture(input int ncyc);
    obs_mrld = '0; obs_rsload = '0; obs_rsshr = '0; obs_done = '0; obs_busy = '0;
    obs_tall = '0; obs_tany = '0; obs_rsload_t = '0;
    for (int c = 0; c < ncyc; c++) begin
      obs_mrld[c]     = mrld;
      obs_rsload[c]   = rsload;
      obs_rsshr[c]    = rsshr;
      obs_done[c]     = done;
      obs_busy[c]     = busy;
      obs_tall[c]     = mrld_t & mdld_t & rsclear_t & rsload_t & rsshr_t & done_t;
      obs_tany[c]     = mrld_t | mdld_t | rsclear_t | rsshr_t | done_t;
      obs_rsload_t[c] = rsload_t;
      cap_prod[c]     = rs_m[7:0];
      tick();
      if (!hold) begin
        start   = 1'b0;
        start_t = 1'b0;
      end
    end
    start   = 1'b0;
    start_t = 1'b0;
    hold    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (all_outs() !== 13'b0) begin
      errors++;
      $display("FAIL reset_hold: outputs %b expected 0", all_outs());
    end
    rst = 1'b0;
    tick();
    checks++;
    if (all_outs() !== 13'b0) begin
      errors++;
      $display("FAIL reset_release: outputs %b expected 0", all_outs());
    end
  endtask

  task automatic test_basic_3x5();
    mr_in = 4'd3; md_in = 4'd5; start = 1'b1;
    capture(12);
    checks++;
    if (obs_rsload[11:0] !== 12'h014) begin
      errors++; $display("FAIL basic_rsload: got %h expected 014", obs_rsload[11:0]);
    end
    checks++;
    if (obs_rsshr[11:0] !== 12'h2A8) begin
      errors++; $display("FAIL basic_rsshr: got %h expected 2a8", obs_rsshr[11:0]);
    end
    checks++;
    if (obs_done[11:0] !== 12'h400) begin
      errors++; $display("FAIL basic_done: got %h expected 400", obs_done[11:0]);
    end
    checks++;
    if (obs_busy[11:0] !== 12'h7FE) begin
      errors++; $display("FAIL basic_busy: got %h expected 7fe", obs_busy[11:0]);
    end
    checks++;
    if (obs_mrld[11:0] !== 12'h002) begin
      errors++; $display("FAIL basic_mrld: got %h expected 002", obs_mrld[11:0]);
    end
    checks++;
    if (cap_prod[10] !== 8'd15) begin
      errors++; $display("FAIL basic_product: got %0d expected 15", cap_prod[10]);
    end
    checks++;
    if ((obs_tany[11:0] | obs_rsload_t[11:0]) !== 12'h000) begin
      errors++; $display("FAIL basic_taint: got %h expected 000", obs_tany[11:0] | obs_rsload_t[11:0]);
    end
  endtask

  task automatic test_zero_multiplier();
    mr_in = 4'd0; md_in = 4'd9; start = 1'b1;
    capture(12);
    checks++;
    if (obs_rsload[11:0] !== 12'h000) begin
      errors++; $display("FAIL zero_rsload: got %h expected 000", obs_rsload[11:0]);
    end
    checks++;
    if (obs_done[11:0] !== 12'h400) begin
      errors++; $display("FAIL zero_done: got %h expected 400", obs_done[11:0]);
    end
    checks++;
    if (cap_prod[10] !== 8'd0) begin
      errors++; $display("FAIL zero_product: got %0d expected 0", cap_prod[10]);
    end
  endtask

  task automatic test_back_to_back();
    mr_in = 4'd15; md_in = 4'd15; start = 1'b1; hold = 1'b1;
    capture(22);
    checks++;
    if (obs_done[21:0] !== 22'h200400) begin
      errors++; $display("FAIL b2b_done: got %h expected 200400", obs_done[21:0]);
    end
    checks++;
    if (obs_mrld[21:0] !== 22'h001002) begin
      errors++; $display("FAIL b2b_accept: got %h expected 001002", obs_mrld[21:0]);
    end
    checks++;
    if (obs_busy[21:0] !== 22'h3FF7FE) begin
      errors++; $display("FAIL b2b_busy: got %h expected 3ff7fe", obs_busy[21:0]);
    end
    checks++;
    if (obs_rsload[11:0] !== 12'h154) begin
      errors++; $display("FAIL b2b_rsload: got %h expected 154", obs_rsload[11:0]);
    end
    checks++;
    if (cap_prod[10] !== 8'd225) begin
      errors++; $display("FAIL b2b_product1: got %0d expected 225", cap_prod[10]);
    end
    checks++;
    if (cap_prod[21] !== 8'd225) begin
      errors++; $display("FAIL b2b_product2: got %0d expected 225", cap_prod[21]);
    end
    checks++;
    if ((obs_rsload & obs_rsshr) !== 32'h0) begin
      errors++; $display("FAIL b2b_exclusive: got %h expected 0", obs_rsload & obs_rsshr);
    end
    tick();
  endtask

  task automatic test_mr_taint();
    mr_in = 4'd5; md_in = 4'd3; start = 1'b1; mr_t_in = 1'b1;
    capture(12);
    mr_t_in = 1'b0;
    checks++;
    if (obs_rsload_t[11:0] !== 12'h154) begin
      errors++; $display("FAIL mrtaint_rsload_t: got %h expected 154", obs_rsload_t[11:0]);
    end
    checks++;
    if (obs_tany[11:0] !== 12'h000) begin
      errors++; $display("FAIL mrtaint_others: got %h expected 000", obs_tany[11:0]);
    end
    checks++;
    if (cap_prod[10] !== 8'd15) begin
      errors++; $display("FAIL mrtaint_product: got %0d expected 15", cap_prod[10]);
    end
  endtask

  task automatic test_start_taint();
    mr_in = 4'd3; md_in = 4'd5; start = 1'b1; start_t = 1'b1;
    capture(12);
    checks++;
    if (obs_tall[11:0] !== 12'hFFE) begin
      errors++; $display("FAIL staint_first: got %h expected ffe", obs_tall[11:0]);
    end
    mr_in = 4'd2; md_in = 4'd7; start = 1'b1;
    capture(12);
    checks++;
    if (obs_tall[11:0] !== 12'hFFF) begin
      errors++; $display("FAIL staint_sticky: got %h expected fff", obs_tall[11:0]);
    end
    checks++;
    if (cap_prod[10] !== 8'd14) begin
      errors++; $display("FAIL staint_product: got %0d expected 14", cap_prod[10]);
    end
  endtask

  task automatic test_reset_midop();
    mr_in = 4'd3; md_in = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if ({rsshr, busy} !== 2'b11) begin
      errors++; $display("FAIL midrst_in_shift: rsshr,busy %b expected 11", {rsshr, busy});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 13'b0) begin
      errors++; $display("FAIL midrst_async: outputs %b expected 0", all_outs());
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (all_outs() !== 13'b0) begin
      errors++; $display("FAIL midrst_after: outputs %b expected 0", all_outs());
    end
    mr_in = 4'd3; md_in = 4'd5; start = 1'b1;
    capture(12);
    checks++;
    if (obs_done[11:0] !== 12'h400) begin
      errors++; $display("FAIL midrst_done: got %h expected 400", obs_done[11:0]);
    end
    checks++;
    if (cap_prod[10] !== 8'd15) begin
      errors++; $display("FAIL midrst_product: got %0d expected 15", cap_prod[10]);
    end
    checks++;
    if ((obs_tany[11:0] | obs_rsload_t[11:0]) !== 12'h000) begin
      errors++; $display("FAIL midrst_taint: got %h expected 000", obs_tany[11:0] | obs_rsload_t[11:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_3x5();
    test_zero_multiplier();
    test_back_to_back();
    test_mr_taint();
    test_start_taint();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
